// File: rtl/fifo_burst_writer.sv
// Write-side burst producer for the distributed FIFO controller (wr_clk domain).
// Define FIFO_BURST_WRITER_OREG_EN to register fifo_w_en/fifo_wdata (one extra cycle, one extra entry reserved).
module fifo_burst_writer #(
  parameter int DEPTH      = 9,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 16
) (
  input  logic                  wr_clk,
  input  logic                  wrst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  fifo_w_en,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_wfull,
  input  logic [DEPTH:0]        fifo_wr_water_level,
  output logic                  burst_done,
  output logic [15:0]           burst_cnt,
  output logic                  overflow_err
);

  localparam int CW = $clog2(BURST_LEN) + 1;
`ifdef FIFO_BURST_WRITER_OREG_EN
  localparam int NEED = BURST_LEN + 1;
`else
  localparam int NEED = BURST_LEN;
`endif
  localparam logic [DEPTH+1:0] CAPACITY = (DEPTH+2)'(1) << DEPTH;
  localparam logic [DEPTH+1:0] NEED_V   = (DEPTH+2)'(NEED);
  localparam logic [CW-1:0]    LAST_IDX = CW'(BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [CW-1:0]   beat_cnt;
  logic [DEPTH+1:0] free;
  logic            room;
  logic            accept;
  logic            burst_end;

  // The level lags reads, so this test only ever underestimates the real room.
  assign free      = CAPACITY - {1'b0, fifo_wr_water_level};
  assign room      = (free >= NEED_V);
  assign s_ready   = (state == BURST) && !fifo_wfull;
  assign accept    = s_valid && s_ready;
  assign burst_end = accept && (s_last || (beat_cnt == LAST_IDX));

`ifdef FIFO_BURST_WRITER_OREG_EN
  always_ff @(posedge wr_clk or posedge wrst) begin
    if (wrst) begin
      fifo_w_en  <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      fifo_w_en  <= accept;
      fifo_wdata <= accept ? s_data : '0;
    end
  end
`else
  // Data is forced to zero off-beat so the bus reads 0 whenever no write is issued.
  assign fifo_w_en  = accept;
  assign fifo_wdata = accept ? s_data : '0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wr_clk or posedge wrst) begin
    if (wrst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      burst_done   <= 1'b0;
      burst_cnt    <= '0;
      overflow_err <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid && room) begin
            state    <= BURST;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (accept) beat_cnt <= beat_cnt + CW'(1);
          if (burst_end) begin
            state      <= IDLE;
            burst_done <= 1'b1;
            burst_cnt  <= burst_cnt + 16'd1;
          end
          // Full during an admitted burst means admission was wrong somewhere.
          if (s_valid && fifo_wfull) overflow_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
`ifdef FIFO_BURST_WRITER_OREG_EN
      if (fifo_wfull && fifo_w_en) overflow_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Self-checking bench for fifo_burst_writer (default build): directed cases plus random
// traffic, compared every cycle against a transaction-level model of bursts and FIFO occupancy.
module tb_fifo_burst_writer;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int BL    = 4;
  localparam int CAP   = 1 << DEPTH;
  localparam int NEED  = BL;

  logic          wr_clk = 1'b0;
  logic          wrst   = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          fifo_w_en;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_wfull = 1'b0;
  logic [DEPTH:0] fifo_wr_water_level = '0;
  logic          burst_done;
  logic [15:0]   burst_cnt;
  logic          overflow_err;

  fifo_burst_writer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .wr_clk(wr_clk), .wrst(wrst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .fifo_w_en(fifo_w_en), .fifo_wdata(fifo_wdata),
    .fifo_wfull(fifo_wfull), .fifo_wr_water_level(fifo_wr_water_level),
    .burst_done(burst_done), .burst_cnt(burst_cnt), .overflow_err(overflow_err)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: whether a burst is open, beats written in it, pending done pulse,
  // completed bursts, sticky error and the FIFO occupancy seen by the controller.
  bit m_busy, m_done, m_ovf, m_last_wen;
  int m_beats, m_cnt, occ;
  int lvl_force = -1;
  bit full_force = 1'b0;
  int n_wr, n_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_done = 0; m_ovf = 0; m_beats = 0; m_cnt = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare just after, advance the model.
  task automatic cycle(input bit v, input bit l, input int reads);
    bit exp_ready, exp_wen;
    @(negedge wr_clk);
    s_valid = v;
    s_last  = l;
    s_data  = DW'($urandom);
    fifo_wr_water_level = (DEPTH+1)'((lvl_force >= 0) ? lvl_force : occ);
    fifo_wfull = full_force || (occ >= CAP);
    #1;
    exp_ready = m_busy && !fifo_wfull;
    exp_wen   = exp_ready && v;
    check("s_ready", s_ready, exp_ready);
    check("w_en", fifo_w_en, exp_wen);
    check("wdata", fifo_wdata, exp_wen ? s_data : '0);
    check("burst_done", burst_done, m_done);
    check("burst_cnt", burst_cnt, 32'(m_cnt & 16'hffff));
    check("overflow", overflow_err, m_ovf);
    n_wr   += int'(fifo_w_en);
    n_done += int'(burst_done);
    m_last_wen = exp_wen;
    m_done = 0;
    if (m_busy) begin
      if (v && fifo_wfull) m_ovf = 1;
      if (exp_wen) begin
        m_beats++;
        if (l || m_beats == BL) begin
          m_busy = 0;
          m_done = 1;
          m_cnt++;
        end
      end
    end else if (v && (CAP - int'(fifo_wr_water_level)) >= NEED) begin
      m_busy  = 1;
      m_beats = 0;
    end
    occ = occ + int'(exp_wen);
    if (reads > 0) occ = (occ > reads) ? occ - reads : 0;
  endtask

  task automatic do_reset(input bit v);
    @(negedge wr_clk);
    wrst = 1'b1;
    s_valid = v;
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_w_en", fifo_w_en, 0);
    check("rst_wdata", fifo_wdata, 0);
    check("rst_done", burst_done, 0);
    check("rst_cnt", burst_cnt, 0);
    check("rst_overflow", overflow_err, 0);
    model_clear();
    @(negedge wr_clk);
    wrst = 1'b0;
    s_valid = 1'b0;
  endtask

  // Stream beats until n accepted beats (per the model), marking s_last on beat last_at.
  task automatic send(input int n, input int last_at);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 200) begin
      cycle(1'b1, (sent + 1) == last_at, 0);
      sent += int'(m_last_wen);
      guard++;
    end
    check("send_budget", 32'(sent), 32'(n));
  endtask

  task automatic idle(input int n, input int reads);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, reads);
  endtask

  initial begin
    int w0, d0;
    occ = 0;
    model_clear();
    do_reset(1'b0);

    // Eight continuous beats, s_last on the eighth: two full bursts.
    n_wr = 0; n_done = 0;
    send(8, 8);
    idle(2, 0);
    check("t1_writes", 32'(n_wr), 8);
    check("t1_done_pulses", 32'(n_done), 2);
    check("t1_burst_cnt", burst_cnt, 2);
    idle(3, 4);

    // Level 13 leaves 3 free: no admission; 12 admits one cycle after sampling.
    lvl_force = 13;
    n_wr = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 0);
    check("t2_blocked_writes", 32'(n_wr), 0);
    lvl_force = 12;
    cycle(1'b1, 1'b0, 0);
    check("t2_ready_at_sample", s_ready, 0);
    cycle(1'b1, 1'b0, 0);
    check("t2_ready_after", s_ready, 1);
    send(3, 3);
    lvl_force = -1;
    idle(4, 4);

    // Early end on beat 3, then a full burst proves beat count restarts at 0.
    n_wr = 0; n_done = 0;
    send(3, 3);
    idle(1, 0);
    check("t3_writes", 32'(n_wr), 3);
    check("t3_done_pulses", 32'(n_done), 1);
    w0 = n_wr; d0 = n_done;
    send(BL, 0);
    idle(2, 4);
    check("t3_next_writes", 32'(n_wr - w0), BL);
    check("t3_next_done", 32'(n_done - d0), 1);
    idle(2, 4);

    // Gaps inside a burst: valid 1,0,0,1,1 writes exactly three beats.
    cycle(1'b1, 1'b0, 0);
    n_wr = 0;
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 0);
    check("t4_writes", 32'(n_wr), 3);
    idle(3, 4);

    // Forced full inside a burst sets a sticky error cleared only by reset.
    cycle(1'b1, 1'b0, 0);
    full_force = 1'b1;
    n_wr = 0;
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    check("t5_no_write", 32'(n_wr), 0);
    full_force = 1'b0;
    idle(3, 0);
    check("t5_sticky", overflow_err, 1);
    do_reset(1'b0);
    check("t5_cleared", overflow_err, 0);
    idle(2, 4);

    // Reset during beat 2 of a burst, then a normal burst from a zero count.
    send(1, 0);
    do_reset(1'b1);
    idle(2, 4);
    send(BL, 0);
    idle(1, 0);
    check("t6_cnt_after_reset", burst_cnt, 1);
    idle(3, 4);

    // Random traffic with a reader draining the FIFO.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 4) != 0, ($urandom % 6) == 0, int'($urandom % 2));
    idle(BL + 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
